// File: rtl/corevx_tlb_pkg.sv
// Shared command encodings, widths and controller state for the corevx TLB slice.
package corevx_tlb_pkg;

  localparam int unsigned VPN_W = 20;
  localparam int unsigned PPN_W = 22;
  localparam int unsigned TAG_W = 8;

  localparam logic [1:0] TLB_CMD_NONE       = 2'd0;
  localparam logic [1:0] TLB_CMD_RESOLVE    = 2'd1;
  localparam logic [1:0] TLB_CMD_WRITE      = 2'd2;
  localparam logic [1:0] TLB_CMD_INVALIDATE = 2'd3;

  typedef enum logic {
    ST_FLUSH = 1'b0,
    ST_READY = 1'b1
  } tlb_ctrl_state_e;

endpackage

// Legacy command macros resolve to the package constants so old call sites keep working.
`ifndef TLB_CMD_NONE
`define TLB_CMD_NONE corevx_tlb_pkg::TLB_CMD_NONE
`endif
`ifndef TLB_CMD_RESOLVE
`define TLB_CMD_RESOLVE corevx_tlb_pkg::TLB_CMD_RESOLVE
`endif
`ifndef TLB_CMD_WRITE
`define TLB_CMD_WRITE corevx_tlb_pkg::TLB_CMD_WRITE
`endif
`ifndef TLB_CMD_INVALIDATE
`define TLB_CMD_INVALIDATE corevx_tlb_pkg::TLB_CMD_INVALIDATE
`endif

// File: rtl/corevx_tlb_ctrl.sv
// Owns the corevx_tlb command port: invalidate walk after reset/flush, then
// arbitrates flush > refill write > resolve and returns resolve responses a cycle later.
module corevx_tlb_ctrl
  import corevx_tlb_pkg::*;
#(
  parameter int unsigned ENTRIES_W = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_req,
  output logic                 flush_done,
  output logic                 busy,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [VPN_W-1:0]     wr_vaddr,
  input  logic [PPN_W-1:0]     wr_phys,
  input  logic [TAG_W-1:0]     wr_accesstag,
  input  logic                 rs_valid,
  output logic                 rs_ready,
  input  logic [VPN_W-1:0]     rs_vaddr,
  output logic                 rs_resp_valid,
  output logic                 rs_hit,
  output logic [TAG_W-1:0]     rs_accesstag,
  output logic [PPN_W-1:0]     rs_phys,
  output logic [1:0]           tlb_command,
  output logic [ENTRIES_W-1:0] tlb_invalidate_set_index,
  output logic [VPN_W-1:0]     tlb_virtual_address_w,
  output logic [PPN_W-1:0]     tlb_phys_w,
  output logic [TAG_W-1:0]     tlb_accesstag_w,
  output logic [VPN_W-1:0]     tlb_virtual_address,
  input  logic                 tlb_hit,
  input  logic [TAG_W-1:0]     tlb_accesstag_r,
  input  logic [PPN_W-1:0]     tlb_phys_r
);

  localparam logic [ENTRIES_W-1:0] LAST_SET = {ENTRIES_W{1'b1}};

  tlb_ctrl_state_e      state_q, state_d;
  logic [ENTRIES_W-1:0] set_q, set_d;
  logic                 flush_done_q, flush_done_d;
  logic                 resp_valid_q, resp_valid_d;
  logic                 accept_s;
  logic                 wr_sel_s;
  logic                 rs_sel_s;

  // Arbitration and command selection for the current cycle.
  always_comb begin
    wr_sel_s                 = 1'b0;
    rs_sel_s                 = 1'b0;
    tlb_command              = TLB_CMD_NONE;
    tlb_invalidate_set_index = {ENTRIES_W{1'b0}};
    accept_s                 = (state_q == ST_READY) && !flush_req;
    if (state_q == ST_FLUSH) begin
      tlb_command              = TLB_CMD_INVALIDATE;
      tlb_invalidate_set_index = set_q;
    end else if (flush_req) begin
      tlb_command = TLB_CMD_NONE;
    end else if (wr_valid) begin
      wr_sel_s    = 1'b1;
      tlb_command = TLB_CMD_WRITE;
    end else if (rs_valid) begin
      rs_sel_s    = 1'b1;
      tlb_command = TLB_CMD_RESOLVE;
    end else begin
      tlb_command = TLB_CMD_NONE;
    end
  end

  assign busy     = (state_q == ST_FLUSH);
  assign wr_ready = accept_s;
  assign rs_ready = accept_s && !wr_valid;

  // Unselected write/resolve fields are forced to zero so the TLB sees clean buses.
  always_comb begin
    tlb_virtual_address_w = {VPN_W{1'b0}};
    tlb_phys_w            = {PPN_W{1'b0}};
    tlb_accesstag_w       = {TAG_W{1'b0}};
    tlb_virtual_address   = {VPN_W{1'b0}};
    if (wr_sel_s) begin
      tlb_virtual_address_w = wr_vaddr;
      tlb_phys_w            = wr_phys;
      tlb_accesstag_w       = wr_accesstag;
    end else if (rs_sel_s) begin
      tlb_virtual_address = rs_vaddr;
    end else begin
      tlb_virtual_address = {VPN_W{1'b0}};
    end
  end

  // Walk sequencing, flush restart and response strobe generation.
  always_comb begin
    state_d      = state_q;
    set_d        = set_q;
    flush_done_d = 1'b0;
    resp_valid_d = rs_sel_s;
    case (state_q)
      ST_FLUSH: begin
        if (flush_req) begin
          set_d = {ENTRIES_W{1'b0}};
        end else if (set_q == LAST_SET) begin
          state_d      = ST_READY;
          set_d        = {ENTRIES_W{1'b0}};
          flush_done_d = 1'b1;
        end else begin
          set_d = set_q + ENTRIES_W'(1'b1);
        end
      end
      ST_READY: begin
        if (flush_req) begin
          state_d = ST_FLUSH;
          set_d   = {ENTRIES_W{1'b0}};
        end else begin
          state_d = ST_READY;
        end
      end
      default: begin
        state_d      = ST_FLUSH;
        set_d        = {ENTRIES_W{1'b0}};
        resp_valid_d = 1'b0;
      end
    endcase
  end

  // State registers; reset restarts the walk at set 0 and drops any pending response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_FLUSH;
      set_q        <= {ENTRIES_W{1'b0}};
      flush_done_q <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      set_q        <= set_d;
      flush_done_q <= flush_done_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign flush_done    = flush_done_q;
  assign rs_resp_valid = resp_valid_q;
  // The TLB registers its lookup, so its result lines up with our delayed strobe.
  assign rs_hit        = resp_valid_q & tlb_hit;
  assign rs_accesstag  = resp_valid_q ? tlb_accesstag_r : {TAG_W{1'b0}};
  assign rs_phys       = resp_valid_q ? tlb_phys_r : {PPN_W{1'b0}};

endmodule

// File: tb/tb_corevx_tlb_ctrl.sv
// Directed plus randomized bench for corevx_tlb_ctrl with a behavioural TLB and reference map.
`timescale 1ns/1ps
module tb_corevx_tlb_ctrl;
  import corevx_tlb_pkg::*;

  localparam int ENTRIES_W = 1;
  localparam int NSETS     = 1 << ENTRIES_W;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 flush_req = 1'b0;
  logic                 flush_done;
  logic                 busy;
  logic                 wr_valid = 1'b0;
  logic                 wr_ready;
  logic [19:0]          wr_vaddr = 20'h0;
  logic [21:0]          wr_phys = 22'h0;
  logic [7:0]           wr_accesstag = 8'h0;
  logic                 rs_valid = 1'b0;
  logic                 rs_ready;
  logic [19:0]          rs_vaddr = 20'h0;
  logic                 rs_resp_valid;
  logic                 rs_hit;
  logic [7:0]           rs_accesstag;
  logic [21:0]          rs_phys;
  logic [1:0]           tlb_command;
  logic [ENTRIES_W-1:0] tlb_invalidate_set_index;
  logic [19:0]          tlb_virtual_address_w;
  logic [21:0]          tlb_phys_w;
  logic [7:0]           tlb_accesstag_w;
  logic [19:0]          tlb_virtual_address;
  logic                 tlb_hit = 1'b0;
  logic [7:0]           tlb_accesstag_r = 8'h0;
  logic [21:0]          tlb_phys_r = 22'h0;

  corevx_tlb_ctrl #(.ENTRIES_W(ENTRIES_W)) dut (
    .clk(clk), .rst(rst), .flush_req(flush_req), .flush_done(flush_done), .busy(busy),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_vaddr(wr_vaddr), .wr_phys(wr_phys),
    .wr_accesstag(wr_accesstag), .rs_valid(rs_valid), .rs_ready(rs_ready),
    .rs_vaddr(rs_vaddr), .rs_resp_valid(rs_resp_valid), .rs_hit(rs_hit),
    .rs_accesstag(rs_accesstag), .rs_phys(rs_phys), .tlb_command(tlb_command),
    .tlb_invalidate_set_index(tlb_invalidate_set_index),
    .tlb_virtual_address_w(tlb_virtual_address_w), .tlb_phys_w(tlb_phys_w),
    .tlb_accesstag_w(tlb_accesstag_w), .tlb_virtual_address(tlb_virtual_address),
    .tlb_hit(tlb_hit), .tlb_accesstag_r(tlb_accesstag_r), .tlb_phys_r(tlb_phys_r)
  );

  always #5 clk = ~clk;

  // Behavioural TLB driven purely by the controller's command port.
  logic [29:0] tlb_mem [logic [19:0]];
  logic [19:0] kill_q [$];
  always @(posedge clk) begin
    case (tlb_command)
      TLB_CMD_WRITE: tlb_mem[tlb_virtual_address_w] = {tlb_accesstag_w, tlb_phys_w};
      TLB_CMD_INVALIDATE: begin
        kill_q.delete();
        foreach (tlb_mem[k]) if (k[ENTRIES_W-1:0] == tlb_invalidate_set_index) kill_q.push_back(k);
        foreach (kill_q[j]) tlb_mem.delete(kill_q[j]);
      end
      TLB_CMD_RESOLVE: begin
        if (tlb_mem.exists(tlb_virtual_address)) begin
          tlb_hit         <= 1'b1;
          tlb_accesstag_r <= tlb_mem[tlb_virtual_address][29:22];
          tlb_phys_r      <= tlb_mem[tlb_virtual_address][21:0];
        end else begin
          tlb_hit         <= 1'b0;
          tlb_accesstag_r <= 8'h0;
          tlb_phys_r      <= 22'h0;
        end
      end
      default: ;
    endcase
  end

  // Reference model: expected translations plus walk progress and pending response.
  logic [29:0] ref_mem [logic [19:0]];
  int          walk_left = NSETS;
  logic        exp_done = 1'b0;
  logic        resp_pending = 1'b0;
  logic        exp_hit = 1'b0;
  logic [29:0] exp_data = 30'h0;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_checks();
    chk("rst_resp_valid", 32'(rs_resp_valid), 32'h0);
    chk("rst_flush_done", 32'(flush_done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h1);
    chk("rst_wr_ready", 32'(wr_ready), 32'h0);
    chk("rst_rs_ready", 32'(rs_ready), 32'h0);
    chk("rst_cmd", 32'(tlb_command), 32'(TLB_CMD_INVALIDATE));
    chk("rst_index", 32'(tlb_invalidate_set_index), 32'h0);
    chk("rst_vaddr_r", 32'(tlb_virtual_address), 32'h0);
    chk("rst_vaddr_w", 32'(tlb_virtual_address_w), 32'h0);
    chk("rst_rs_phys", 32'(rs_phys), 32'h0);
  endtask

  // Called at a negedge; asserts reset mid-cycle, holds, then releases before the next edge.
  task automatic do_reset(input int ncyc);
    rst = 1'b1; flush_req = 1'b0; wr_valid = 1'b0; rs_valid = 1'b1;
    #1;
    reset_checks();
    repeat (ncyc) @(negedge clk);
    #1;
    reset_checks();
    rs_valid = 1'b0;
    rst = 1'b0;
    walk_left = NSETS; exp_done = 1'b0; resp_pending = 1'b0;
    ref_mem.delete();
  endtask

  // One clock cycle: drive, check comb and registered outputs, advance the model.
  task automatic cycle(input logic fr, input logic wv, input logic rv, input logic [19:0] wva,
                       input logic [21:0] wph, input logic [7:0] wtg, input logic [19:0] rva);
    logic [1:0] ecmd;
    logic       busy_e;
    flush_req = fr; wr_valid = wv; rs_valid = rv;
    wr_vaddr = wva; wr_phys = wph; wr_accesstag = wtg; rs_vaddr = rva;
    #1;
    busy_e = (walk_left > 0);
    if (busy_e)  ecmd = TLB_CMD_INVALIDATE;
    else if (fr) ecmd = TLB_CMD_NONE;
    else if (wv) ecmd = TLB_CMD_WRITE;
    else if (rv) ecmd = TLB_CMD_RESOLVE;
    else         ecmd = TLB_CMD_NONE;
    chk("busy", 32'(busy), 32'(busy_e));
    chk("wr_ready", 32'(wr_ready), 32'(!busy_e && !fr));
    chk("rs_ready", 32'(rs_ready), 32'(!busy_e && !fr && !wv));
    chk("tlb_command", 32'(tlb_command), 32'(ecmd));
    if (busy_e) chk("inv_index", 32'(tlb_invalidate_set_index), 32'(NSETS - walk_left));
    chk("tlb_vaddr_w", 32'(tlb_virtual_address_w), (ecmd == TLB_CMD_WRITE) ? 32'(wva) : 32'h0);
    chk("tlb_phys_w", 32'(tlb_phys_w), (ecmd == TLB_CMD_WRITE) ? 32'(wph) : 32'h0);
    chk("tlb_tag_w", 32'(tlb_accesstag_w), (ecmd == TLB_CMD_WRITE) ? 32'(wtg) : 32'h0);
    chk("tlb_vaddr", 32'(tlb_virtual_address), (ecmd == TLB_CMD_RESOLVE) ? 32'(rva) : 32'h0);
    chk("flush_done", 32'(flush_done), 32'(exp_done));
    chk("rs_resp_valid", 32'(rs_resp_valid), 32'(resp_pending));
    if (resp_pending) begin
      chk("rs_hit", 32'(rs_hit), 32'(exp_hit));
      if (exp_hit) begin
        chk("rs_phys", 32'(rs_phys), 32'(exp_data[21:0]));
        chk("rs_accesstag", 32'(rs_accesstag), 32'(exp_data[29:22]));
      end
    end
    exp_done = 1'b0;
    resp_pending = 1'b0;
    if (busy_e) begin
      if (fr) walk_left = NSETS;
      else begin
        walk_left--;
        if (walk_left == 0) exp_done = 1'b1;
      end
    end else if (fr) begin
      walk_left = NSETS;
      ref_mem.delete();
    end else if (wv) begin
      ref_mem[wva] = {wtg, wph};
    end else if (rv) begin
      resp_pending = 1'b1;
      exp_hit  = ref_mem.exists(rva);
      exp_data = exp_hit ? ref_mem[rva] : 30'h0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 20'h0, 22'h0, 8'h0, 20'h0);
  endtask
  task automatic wr(input logic [19:0] va, input logic [21:0] ph, input logic [7:0] tg);
    cycle(1'b0, 1'b1, 1'b0, va, ph, tg, 20'h0);
  endtask
  task automatic rs(input logic [19:0] va);
    cycle(1'b0, 1'b0, 1'b1, 20'h0, 22'h0, 8'h0, va);
  endtask
  task automatic fl();
    cycle(1'b1, 1'b0, 1'b0, 20'h0, 22'h0, 8'h0, 20'h0);
  endtask

  initial begin
    logic        hw, hr, fr, acc_w, acc_r;
    logic [19:0] rwva, rrva;
    logic [21:0] rwph;
    logic [7:0]  rwtg;
    logic [31:0] rnd;
    @(negedge clk);
    do_reset(2);
    // Walk: index 0, index 1, then READY with flush_done on the third cycle.
    idle(); idle(); idle();
    wr(20'h100, 22'h0000F5, 8'hFF);
    rs(20'h100);
    idle();
    cycle(1'b0, 1'b1, 1'b1, 20'h55, 22'h0000FE, 8'h12, 20'h55);
    rs(20'h55);
    idle();
    wr(20'h56, 22'h001234, 8'h34);
    wr(20'h101, 22'h3ABCDE, 8'h77);
    rs(20'h55); rs(20'h56); rs(20'h100); rs(20'h101);
    idle();
    // Flush from READY, then miss after the walk.
    fl(); idle(); idle();
    rs(20'h55);
    idle();
    // Flush restarted mid-walk, then reset with a response in flight.
    wr(20'h200, 22'h000321, 8'h5A);
    fl(); idle();
    fl(); idle(); idle(); idle();
    rs(20'h200);
    wr(20'h300, 22'h000111, 8'h22);
    rs(20'h300);
    do_reset(2);
    idle(); idle(); idle();
    rs(20'h300);
    idle();
    // Randomized traffic with requesters holding until accepted.
    hw = 1'b0; hr = 1'b0;
    rwva = 20'h0; rrva = 20'h0; rwph = 22'h0; rwtg = 8'h0;
    for (int i = 0; i < 400; i++) begin
      fr = ($urandom_range(0, 39) == 0);
      if (!hw && $urandom_range(0, 2) == 0) begin
        hw = 1'b1;
        rwva = 20'h40 + 20'($urandom_range(0, 7));
        rnd = $urandom; rwph = rnd[21:0];
        rnd = $urandom; rwtg = rnd[7:0];
      end
      if (!hr && $urandom_range(0, 1) == 0) begin
        hr = 1'b1;
        rrva = 20'h40 + 20'($urandom_range(0, 7));
      end
      acc_w = hw && (walk_left == 0) && !fr;
      acc_r = hr && (walk_left == 0) && !fr && !hw;
      cycle(fr, hw, hr, rwva, rwph, rwtg, rrva);
      if (acc_w) hw = 1'b0;
      if (acc_r) hr = 1'b0;
    end
    idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
